// File: rtl/lut3_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lut3_pkg
// Description : Shared constants, state encoding and helpers for the 3-input
//               truth-table evaluator pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package lut3_pkg;

    // Well-known truth tables; bit k holds f for {x,y,z} == k
    localparam logic [7:0] TT_SOP_DEFAULT = 8'hCA;  // xy + yz + x'z
    localparam logic [7:0] TT_MAJ         = 8'hE8;  // majority of three
    localparam logic [7:0] TT_XOR3        = 8'h96;  // odd parity
    localparam logic [7:0] TT_AND3        = 8'h80;  // all three set

    // The sweep walks every {x,y,z} combination, so its index is 3 bits wide
    // and the table holds one bit per index value.
    localparam int SWEEP_IDX_W = 3;
    localparam int TT_BITS     = 1 << SWEEP_IDX_W;

    // Sweep engine states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } sweep_state_e;

    // True when a table matches one of the named functions above
    function automatic logic tt_is_builtin(input logic [TT_BITS-1:0] tt);
        return (tt == TT_SOP_DEFAULT) || (tt == TT_MAJ) ||
               (tt == TT_XOR3)        || (tt == TT_AND3);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lut3_lane.sv
`default_nettype none
// ============================================================================
// Module      : lut3_lane
// Description : Single-bit combinational lookup of a 3-input function held
//               as an 8-entry truth table.
// Revision    : 1.0 - initial release
// ============================================================================
module lut3_lane
    import lut3_pkg::*;
(
    input  logic [TT_BITS-1:0] tt,
    input  logic               x,
    input  logic               y,
    input  logic               z,
    output logic               f
);

    // x is the most significant select bit, z the least
    assign f = tt[{x, y, z}];

endmodule
`default_nettype wire

// File: rtl/lut3_eval_pipe.sv
`default_nettype none
// ============================================================================
// Module      : lut3_eval_pipe
// Description : WIDTH-lane registered evaluator of a runtime-loadable 3-input
//               Boolean function, with a valid/ready stream interface and a
//               self-sweep engine that reconstructs the active truth table.
// Revision    : 1.0 - initial release
// ============================================================================
module lut3_eval_pipe
    import lut3_pkg::*;
#(
    parameter int               WIDTH    = 4,
    parameter logic [TT_BITS-1:0] TT_RESET = TT_SOP_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 cfg_we,
    input  logic [TT_BITS-1:0]   cfg_tt,

    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    input  logic [WIDTH-1:0]     z,

    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     f,

    input  logic                 sweep_start,
    output logic                 sweep_busy,
    output logic                 sweep_done,
    output logic [TT_BITS-1:0]   sweep_sig
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [TT_BITS-1:0]     r_tt;
    logic [WIDTH-1:0]       r_f;
    logic                   r_out_valid;

    sweep_state_e           r_state;
    logic [SWEEP_IDX_W-1:0] r_idx;
    logic                   r_busy;
    logic                   r_done;
    logic [TT_BITS-1:0]     r_sig;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]       w_lane_f;
    logic                   w_sweep_f;
    logic                   w_in_ready;
    logic                   w_in_fire;
    logic                   w_sweep_last;

    // Input is taken only while the sweep engine is idle and the output
    // register is empty or being drained in this same cycle.
    assign w_in_ready   = (r_state == IDLE) && (!r_out_valid || out_ready);
    assign w_in_fire    = in_valid && w_in_ready;
    assign w_sweep_last = &r_idx;

    // ------------------------------------------------------------------
    // Datapath lookup, one lane per bit
    // ------------------------------------------------------------------
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_lane
            lut3_lane u_lane (
                .tt (r_tt),
                .x  (x[i]),
                .y  (y[i]),
                .z  (z[i]),
                .f  (w_lane_f[i])
            );
        end
    endgenerate

    // Dedicated lookup for the sweep; the index bits play the role of {x,y,z}
    lut3_lane u_sweep_lane (
        .tt (r_tt),
        .x  (r_idx[2]),
        .y  (r_idx[1]),
        .z  (r_idx[0]),
        .f  (w_sweep_f)
    );

    // ------------------------------------------------------------------
    // Truth-table register; frozen while the sweep is reading it so the
    // captured signature is self-consistent. A word accepted on the same
    // edge as a write sees the previous table because r_tt is registered.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tt <= TT_RESET;
        end else if (cfg_we && !r_busy) begin
            r_tt <= cfg_tt;
        end
    end

    // ------------------------------------------------------------------
    // Output register: load on accept, clear valid on drain, hold on stall
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_f         <= '0;
            r_out_valid <= 1'b0;
        end else if (w_in_fire) begin
            r_f         <= w_lane_f;
            r_out_valid <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Sweep engine: walk indices 0..7, record each lookup into the
    // signature, then raise done for exactly one cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sig   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (sweep_start) begin
                        r_state <= SWEEP;
                        r_idx   <= '0;
                        r_sig   <= '0;
                        r_busy  <= 1'b1;
                    end
                end

                SWEEP: begin
                    r_sig[r_idx] <= w_sweep_f;
                    // The index wraps to 0 on the final step, leaving it
                    // ready for the next sweep.
                    r_idx        <= r_idx + SWEEP_IDX_W'(1);
                    if (w_sweep_last) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end

                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end

                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready   = w_in_ready;
    assign out_valid  = r_out_valid;
    assign f          = r_f;
    assign sweep_busy = r_busy;
    assign sweep_done = r_done;
    assign sweep_sig  = r_sig;

endmodule
`default_nettype wire

// File: tb/tb_lut3_eval_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_lut3_eval_pipe
// Description : Self-checking bench for lut3_eval_pipe: directed vector table,
//               randomized stream against a queue-based reference model, and
//               sweep / reset corner sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lut3_eval_pipe;
    import lut3_pkg::*;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cfg_we = 1'b0;
    logic [7:0]   cfg_tt = 8'h00;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] x = '0, y = '0, z = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] f;
    logic         sweep_start = 1'b0;
    logic         sweep_busy;
    logic         sweep_done;
    logic [7:0]   sweep_sig;

    lut3_eval_pipe #(.WIDTH(W), .TT_RESET(TT_SOP_DEFAULT)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_tt      (cfg_tt),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .x           (x),
        .y           (y),
        .z           (z),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .f           (f),
        .sweep_start (sweep_start),
        .sweep_busy  (sweep_busy),
        .sweep_done  (sweep_done),
        .sweep_sig   (sweep_sig)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Reference: each lane reads bit (4x+2y+z) of the table
    function automatic logic [W-1:0] model_f(input logic [7:0] tt, input logic [W-1:0] a,
                                             input logic [W-1:0] b, input logic [W-1:0] c);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) begin
            int k;
            k = 4 * int'(a[i]) + 2 * int'(b[i]) + int'(c[i]);
            r[i] = (tt >> k) & 8'h01;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit           cfg;    // load tt before (or with) the word
        bit           same;   // load tt in the same cycle as the word
        logic [7:0]   tt;
        logic [W-1:0] vx, vy, vz, vf;
    } vec_t;

    vec_t vecs[11];
    logic [W-1:0] exp_q[$];
    logic [7:0]   tt_model;

    // Start a sweep (any in_valid set by the caller rides on the same edge),
    // then check its duration, blocking of input, and the captured signature.
    task automatic run_sweep(input logic [7:0] exp_sig, input bit poke_cfg);
        int n;
        sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
        in_valid    = 1'b0;
        n = 0;
        while (sweep_busy === 1'b1 && n < 20) begin
            cfg_we = poke_cfg;
            cfg_tt = 8'h00;
            #1;
            chk("sweep_in_ready", in_ready, 0);
            chk("sweep_done_early", sweep_done, 0);
            tick();
            n++;
        end
        cfg_we = 1'b0;
        chk("sweep_cycles", n, 8);
        chk("sweep_done", sweep_done, 1);
        chk("sweep_sig", sweep_sig, exp_sig);
        tick();
        chk("sweep_done_len", sweep_done, 0);
        chk("sweep_idle_busy", sweep_busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, got, cyc;
        logic fin, fout, vprev;
        logic [W-1:0] cur_f, e;

        // ---------------- reset with random inputs ----------------
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'($urandom); x = W'($urandom); y = W'($urandom); z = W'($urandom);
            cfg_we = 1'($urandom); cfg_tt = 8'($urandom); sweep_start = 1'($urandom);
            out_ready = 1'($urandom);
            tick();
        end
        chk("rst_f", f, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sweep_sig", sweep_sig, 0);
        chk("rst_sweep_busy", sweep_busy, 0);
        in_valid = 0; cfg_we = 0; sweep_start = 0; out_ready = 0;
        rst = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        tt_model = TT_SOP_DEFAULT;

        // ---------------- directed vector table ----------------
        vecs[0]  = '{1'b0, 1'b0, 8'hCA, 4'hC, 4'hA, 4'h6, 4'hA};
        vecs[1]  = '{1'b1, 1'b0, 8'hE8, 4'hC, 4'hA, 4'h6, 4'hE};
        vecs[2]  = '{1'b1, 1'b0, 8'h96, 4'hC, 4'hA, 4'h6, 4'h0};
        vecs[3]  = '{1'b1, 1'b0, 8'h80, 4'hF, 4'hF, 4'hF, 4'hF};
        vecs[4]  = '{1'b0, 1'b0, 8'h80, 4'hF, 4'hF, 4'hE, 4'hE};
        vecs[5]  = '{1'b1, 1'b0, 8'hCA, 4'h1, 4'h0, 4'h0, 4'h0};
        vecs[6]  = '{1'b1, 1'b1, 8'h96, 4'h1, 4'h0, 4'h0, 4'h0};  // old table used
        vecs[7]  = '{1'b0, 1'b0, 8'h96, 4'h1, 4'h0, 4'h0, 4'h1};  // new table now live
        vecs[8]  = '{1'b1, 1'b0, 8'hCA, 4'h1, 4'h1, 4'h1, 4'h1};
        vecs[9]  = '{1'b1, 1'b1, 8'h96, 4'h1, 4'h1, 4'h1, 4'h1};
        vecs[10] = '{1'b0, 1'b0, 8'h96, 4'h1, 4'h1, 4'h1, 4'h1};

        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].cfg && !vecs[i].same) begin
                cfg_we = 1'b1; cfg_tt = vecs[i].tt;
                tick();
                cfg_we = 1'b0;
            end
            x = vecs[i].vx; y = vecs[i].vy; z = vecs[i].vz;
            in_valid = 1'b1;
            if (vecs[i].same) begin
                cfg_we = 1'b1; cfg_tt = vecs[i].tt;
            end
            #1;
            chk($sformatf("vec%0d_in_ready", i), in_ready, 1);
            tick();
            in_valid = 1'b0; cfg_we = 1'b0;
            chk($sformatf("vec%0d_valid", i), out_valid, 1);
            chk($sformatf("vec%0d_f", i), f, vecs[i].vf);
            if (vecs[i].cfg) tt_model = vecs[i].tt;
        end
        tick();
        chk("drain_valid", out_valid, 0);

        // ---------------- back-pressure ----------------
        out_ready = 1'b0;
        in_valid = 1'b1; x = W'($urandom); y = W'($urandom); z = W'($urandom);
        exp_q.push_back(model_f(tt_model, x, y, z));
        tick();
        for (int i = 0; i < 5; i++) begin
            x = W'($urandom); y = W'($urandom); z = W'($urandom);
            #1;
            chk("stall_in_ready", in_ready, 0);
            tick();
            chk("stall_valid", out_valid, 1);
            chk("stall_f", f, exp_q[0]);
        end

        // ---------------- randomized stream vs queue model ----------------
        sent = 1; got = 0; cyc = 0;
        while (got < 33 && cyc < 2000) begin
            in_valid  = (sent < 33) ? ($urandom_range(0, 3) != 0) : 1'b0;
            x = W'($urandom); y = W'($urandom); z = W'($urandom);
            out_ready = (cyc < 8) ? 1'b1 : ($urandom_range(0, 3) != 0);
            #1;
            vprev = out_valid;
            chk("sb_in_ready", in_ready, !vprev || out_ready);
            fin   = in_valid && in_ready;
            fout  = out_valid && out_ready;
            cur_f = f;
            tick();
            if (fout) begin
                if (exp_q.size() == 0) begin
                    chk("sb_spurious", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_word", cur_f, e);
                end
                got++;
            end
            if (fin) begin
                exp_q.push_back(model_f(tt_model, x, y, z));
                sent++;
            end
            chk("sb_valid", out_valid, fin || (vprev && !fout));
            cyc++;
        end
        in_valid = 1'b0;
        chk("sb_count", got, 33);
        chk("sb_queue_empty", exp_q.size(), 0);

        // ---------------- sweep with TT=0x96, word on start edge ----------------
        cfg_we = 1'b1; cfg_tt = TT_XOR3; out_ready = 1'b1;
        tick();
        cfg_we = 1'b0; tt_model = TT_XOR3;
        out_ready = 1'b0;
        in_valid = 1'b1; x = 4'h1; y = 4'h0; z = 4'h0;
        run_sweep(TT_XOR3, 1'b1);              // cfg writes during sweep must be ignored
        chk("sweep_word_valid", out_valid, 1);
        chk("sweep_word_f", f, model_f(tt_model, 4'h1, 4'h0, 4'h0));
        out_ready = 1'b1;
        in_valid = 1'b1; x = 4'h1; y = 4'h0; z = 4'h0;
        tick();
        in_valid = 1'b0;
        chk("post_sweep_tt_kept", f, 4'h1);
        tick();
        chk("sig_holds", sweep_sig, TT_XOR3);

        // ---------------- sweep with the reset table ----------------
        cfg_we = 1'b1; cfg_tt = TT_SOP_DEFAULT;
        tick();
        cfg_we = 1'b0; tt_model = TT_SOP_DEFAULT;
        run_sweep(TT_SOP_DEFAULT, 1'b0);

        // ---------------- reset in the 4th sweep cycle with a stalled word ----------------
        cfg_we = 1'b1; cfg_tt = TT_XOR3;
        tick();
        cfg_we = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b1; x = 4'hF; y = 4'h3; z = 4'h5;
        tick();
        in_valid = 1'b0;
        chk("pre_rst_stall", out_valid, 1);
        sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
        tick(); tick(); tick();
        chk("mid_sweep_sig", sweep_sig, 8'h06);
        chk("mid_sweep_busy", sweep_busy, 1);
        rst = 1'b1;
        #1;
        chk("rst_mid_busy", sweep_busy, 0);
        chk("rst_mid_sig", sweep_sig, 0);
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_f", f, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("rst_mid_in_ready", in_ready, 1);
        run_sweep(TT_SOP_DEFAULT, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
